f_d_reg: RTL and testbench
==========================

// Module: f_d_reg
// PURPOSE
//   F->D pipeline register of the 5-stage MIPS CPU, directly downstream of PC/IM.
//   Captures the fetch-stage PC and instruction and checks the fetch for AdEL.
//   Tracks the branch-delay-slot flag and flushes on exception request (Req) or eret.
//   Feeds the D stage: decoder, branch compare and stall unit.
// PARAMETERS
//   PC_RESET   32'h0000_3000  D_PC value after reset
//   EXC_ENTRY  32'h0000_4180  D_PC loaded when Req flushes the register
//   IM_LO      32'h0000_3000  lowest legal fetch address
//   IM_HI      32'h0000_6ffc  highest legal fetch address (inclusive)
//   EXC_ADEL   5'd4           ExcCode for fetch address error
// PORTS
//   clk         in   1   single clock; all state updates on posedge
//   reset       in   1   synchronous, active-high
//   F_PC        in   32  pc_out of PC
//   F_instr     in   32  IM read data for F_PC
//   F_BD        in   1   D-stage instr is branch/jump => F instr is a delay slot
//   stall       in   1   hold register (stall unit)
//   Req         in   1   CP0 exception/interrupt request, flushes
//   eret_flush  in   1   D-stage instr is eret; kill the fetched slot
//   D_PC        out  32  registered PC
//   D_instr     out  32  registered instruction (0 = nop when killed)
//   D_ExcCode   out  5   registered fetch exception code (0 = none)
//   D_BD        out  1   registered delay-slot flag
//   D_valid     out  1   1 = real fetched instruction, 0 = bubble
// BEHAVIOUR
//   Priority per posedge: reset > Req > stall > eret_flush > normal load.
//   - reset: D_PC=PC_RESET, D_instr=0, D_ExcCode=0, D_BD=0, D_valid=0.
//   - Req: D_PC=EXC_ENTRY, D_instr=0, D_ExcCode=0, D_BD=0, D_valid=0.
//     Req overrides a simultaneous stall.
//   - stall: every output holds its value; eret_flush is ignored this cycle.
//     The eret stays in D and flushes on the first unstalled cycle.
//   - eret_flush: D_PC=F_PC, D_instr=0, D_ExcCode=0, D_BD=0, D_valid=0.
//   - normal: D_PC=F_PC, D_BD=F_BD, D_valid=1.
//     * adel = (F_PC[1:0]!=0) | (F_PC<IM_LO) | (F_PC>IM_HI), all unsigned 32-bit compares.
//     * adel=1: D_instr=0, D_ExcCode=EXC_ADEL.
//     * adel=0: D_instr=F_instr, D_ExcCode=0.
//   - Latency: exactly 1 cycle F->D; there is no combinational path from inputs to outputs.
//   - Boundaries: F_PC=IM_HI is legal; IM_HI+4 and IM_LO-4 raise AdEL.
//     A misaligned PC inside the range also raises AdEL.
//     F_BD is latched together with an AdEL fetch, so CP0 computes EPC=PC-4.
//   - Reset asserted mid-stall or together with Req: reset values win.
// STRUCTURE
//   Shared package/header (cpu_defs): EXC_ADEL, EXC_ENTRY, PC_RESET, IM_LO, IM_HI,
//   and the 5-bit ExcCode width. These constants are shared with CP0, PC and E/M/W regs.
//   One sub-module: f_exc_check (comb).
//     Inputs: F_PC, F_instr. Outputs: adel, instr_ok (F_instr or 0).
//   The register body lives in f_d_reg.
// TESTING
//   1 reset=1 for 2 cycles, then release
//     -> D_PC=3000, D_instr=0, D_valid=0. First posedge after release with F_PC=3000,
//        F_instr=3c011234 -> D_PC=3000, D_instr=3c011234, D_valid=1.
//   2 load F_PC=3004/instr=A; cycle 2 stall=1 with F_PC=3008/instr=B
//     -> D holds 3004/A. Cycle 3 stall=0 -> D shows 3008/B.
//   3 F_PC=3002
//     -> D_instr=0, D_ExcCode=4. F_PC=7000 -> D_ExcCode=4.
//     F_PC=6ffc -> D_ExcCode=0.
//     F_PC=2ffc -> D_ExcCode=4.
//   4 stall=1 & Req=1 in the same cycle
//     -> D_PC=4180, D_instr=0, D_ExcCode=0, D_BD=0, D_valid=0.
//   5 eret_flush=1 & stall=1 -> D holds.
//     Next cycle eret_flush=1, stall=0, F_PC=3010 -> D_PC=3010, D_instr=0, D_valid=0.
//   6 F_BD=1, F_PC=300c
//     -> D_BD=1. Following cycle F_BD=0 -> D_BD=0.
//     Req during a BD-flagged load -> D_BD=0.

Source files
------------

// File: rtl/f_d_reg_pkg.sv
// CPU-wide constants used by the F->D register. CP0, PC and the E/M/W
// registers import the same values.
//   EXC_W     : ExcCode width
//   EXC_ADEL  : ExcCode for a fetch address error
//   EXC_ENTRY : exception handler entry PC
//   PC_RESET  : PC after reset
//   IM_LO/HI  : inclusive legal instruction-memory window
package f_d_reg_pkg;
   localparam int unsigned EXC_W = 5;

   localparam logic [EXC_W-1:0] EXC_NONE = '0;
   localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

   localparam logic [31:0] PC_RESET  = 32'h0000_3000;
   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
   localparam logic [31:0] IM_LO     = 32'h0000_3000;
   localparam logic [31:0] IM_HI     = 32'h0000_6ffc;
endpackage

// File: rtl/f_exc_check.sv
// Combinational fetch address check.
//   F_PC     in  32  fetch address
//   F_instr  in  32  IM data for F_PC
//   adel     out 1   misaligned or outside [IM_LO, IM_HI]
//   instr_ok out 32  F_instr, or 0 (nop) when adel
module f_exc_check
   import f_d_reg_pkg::*;
#(
   parameter logic [31:0] LO = IM_LO,
   parameter logic [31:0] HI = IM_HI
) (
   input  logic [31:0] F_PC,
   input  logic [31:0] F_instr,
   output logic        adel,
   output logic [31:0] instr_ok
);

   always_comb begin
      adel     = (F_PC[1:0] != 2'b00) | (F_PC < LO) | (F_PC > HI);
      instr_ok = adel ? '0 : F_instr;
   end

endmodule

// File: rtl/f_d_reg.sv
// F->D pipeline register. Captures fetch PC/instruction, flags AdEL on
// the fetch, latches the delay-slot flag, and flushes on Req or eret.
//   clk, reset   clock, synchronous active-high reset
//   F_PC/F_instr fetch-stage PC and instruction
//   F_BD         F instruction is a branch delay slot
//   stall        hold all outputs
//   Req          CP0 exception request: flush to EXC_ENTRY
//   eret_flush   kill the fetched slot
//   D_*          registered outputs; D_valid=0 marks a bubble
module f_d_reg
   import f_d_reg_pkg::*;
#(
   parameter logic [31:0] RST_PC = PC_RESET,
   parameter logic [31:0] EXC_PC = EXC_ENTRY
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      F_PC,
   input  logic [31:0]      F_instr,
   input  logic             F_BD,
   input  logic             stall,
   input  logic             Req,
   input  logic             eret_flush,
   output logic [31:0]      D_PC,
   output logic [31:0]      D_instr,
   output logic [EXC_W-1:0] D_ExcCode,
   output logic             D_BD,
   output logic             D_valid
);

   logic        adel;
   logic [31:0] instr_ok;

   f_exc_check #(
      .LO (IM_LO),
      .HI (IM_HI)
   ) u_exc_check (
      .F_PC     (F_PC),
      .F_instr  (F_instr),
      .adel     (adel),
      .instr_ok (instr_ok)
   );

   // Priority: reset > Req > stall > eret_flush > load.
   // Stall leaves every output untouched, so a stalled eret flushes later.
   always_ff @(posedge clk) begin
      if (reset) begin
         D_PC      <= RST_PC;
         D_instr   <= '0;
         D_ExcCode <= EXC_NONE;
         D_BD      <= 1'b0;
         D_valid   <= 1'b0;
      end else if (Req) begin
         D_PC      <= EXC_PC;
         D_instr   <= '0;
         D_ExcCode <= EXC_NONE;
         D_BD      <= 1'b0;
         D_valid   <= 1'b0;
      end else if (!stall) begin
         if (eret_flush) begin
            D_PC      <= F_PC;
            D_instr   <= '0;
            D_ExcCode <= EXC_NONE;
            D_BD      <= 1'b0;
            D_valid   <= 1'b0;
         end else begin
            // BD is kept on AdEL so CP0 can form EPC = PC-4.
            D_PC      <= F_PC;
            D_instr   <= instr_ok;
            D_ExcCode <= adel ? EXC_ADEL : EXC_NONE;
            D_BD      <= F_BD;
            D_valid   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_f_d_reg.sv
// Directed-vector bench for f_d_reg with hand-computed expectations.
module tb_f_d_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] F_PC;
   logic [31:0] F_instr;
   logic        F_BD;
   logic        stall;
   logic        Req;
   logic        eret_flush;
   logic [31:0] D_PC;
   logic [31:0] D_instr;
   logic [4:0]  D_ExcCode;
   logic        D_BD;
   logic        D_valid;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   f_d_reg dut (
      .clk        (clk),
      .reset      (reset),
      .F_PC       (F_PC),
      .F_instr    (F_instr),
      .F_BD       (F_BD),
      .stall      (stall),
      .Req        (Req),
      .eret_flush (eret_flush),
      .D_PC       (D_PC),
      .D_instr    (D_instr),
      .D_ExcCode  (D_ExcCode),
      .D_BD       (D_BD),
      .D_valid    (D_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [4:0] exc, input logic bd, input logic v);
      chk({tag, ".pc"},    D_PC, pc);
      chk({tag, ".instr"}, D_instr, ins);
      chk({tag, ".exc"},   {27'd0, D_ExcCode}, {27'd0, exc});
      chk({tag, ".bd"},    {31'd0, D_BD}, {31'd0, bd});
      chk({tag, ".valid"}, {31'd0, D_valid}, {31'd0, v});
   endtask

   initial begin
      reset = 1'b1; F_PC = 32'h3000; F_instr = 32'h3c01_1234; F_BD = 1'b0;
      stall = 1'b0; Req = 1'b0; eret_flush = 1'b0;

      // 1: reset then first load
      cyc(); cyc();
      chk_all("reset", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
      reset = 1'b0;
      cyc();
      chk_all("first", 32'h3000, 32'h3c01_1234, 5'd0, 1'b0, 1'b1);

      // 2: stall holds, then releases
      F_PC = 32'h3004; F_instr = 32'h8c22_0004;
      cyc();
      chk_all("loadA", 32'h3004, 32'h8c22_0004, 5'd0, 1'b0, 1'b1);
      stall = 1'b1; F_PC = 32'h3008; F_instr = 32'h0043_1820;
      cyc();
      chk_all("stallA", 32'h3004, 32'h8c22_0004, 5'd0, 1'b0, 1'b1);
      stall = 1'b0;
      cyc();
      chk_all("loadB", 32'h3008, 32'h0043_1820, 5'd0, 1'b0, 1'b1);

      // 3: AdEL boundaries
      F_PC = 32'h3002; F_instr = 32'h1111_1111;
      cyc();
      chk_all("misalign", 32'h3002, 32'h0, 5'd4, 1'b0, 1'b1);
      F_PC = 32'h7000;
      cyc();
      chk_all("above", 32'h7000, 32'h0, 5'd4, 1'b0, 1'b1);
      F_PC = 32'h6ffc; F_instr = 32'h2222_2222;
      cyc();
      chk_all("hi_edge", 32'h6ffc, 32'h2222_2222, 5'd0, 1'b0, 1'b1);
      F_PC = 32'h2ffc;
      cyc();
      chk_all("below", 32'h2ffc, 32'h0, 5'd4, 1'b0, 1'b1);
      F_PC = 32'h3000; F_instr = 32'h3333_3333;
      cyc();
      chk_all("lo_edge", 32'h3000, 32'h3333_3333, 5'd0, 1'b0, 1'b1);

      // 4: Req overrides stall (BD also cleared)
      stall = 1'b1; Req = 1'b1; F_BD = 1'b1; F_PC = 32'h3010;
      cyc();
      chk_all("req_stall", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);
      stall = 1'b0; Req = 1'b0; F_BD = 1'b0;

      // 5: stalled eret holds, then flushes
      F_PC = 32'h3008; F_instr = 32'h4444_4444;
      cyc();
      chk_all("pre_eret", 32'h3008, 32'h4444_4444, 5'd0, 1'b0, 1'b1);
      eret_flush = 1'b1; stall = 1'b1; F_PC = 32'h300c;
      cyc();
      chk_all("eret_stall", 32'h3008, 32'h4444_4444, 5'd0, 1'b0, 1'b1);
      stall = 1'b0; F_PC = 32'h3010; F_BD = 1'b1;
      cyc();
      chk_all("eret", 32'h3010, 32'h0, 5'd0, 1'b0, 1'b0);
      eret_flush = 1'b0;

      // 6: delay-slot flag
      F_BD = 1'b1; F_PC = 32'h300c; F_instr = 32'h5555_5555;
      cyc();
      chk_all("bd1", 32'h300c, 32'h5555_5555, 5'd0, 1'b1, 1'b1);
      F_BD = 1'b0; F_PC = 32'h3010;
      cyc();
      chk_all("bd0", 32'h3010, 32'h5555_5555, 5'd0, 1'b0, 1'b1);
      F_BD = 1'b1; F_PC = 32'h7000;
      cyc();
      chk_all("bd_adel", 32'h7000, 32'h0, 5'd4, 1'b1, 1'b1);
      F_PC = 32'h3014; Req = 1'b1;
      cyc();
      chk_all("bd_req", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);
      Req = 1'b0; F_BD = 1'b0;

      // reset wins over stall and over Req
      F_PC = 32'h3020; F_instr = 32'h6666_6666;
      cyc();
      stall = 1'b1; reset = 1'b1;
      cyc();
      chk_all("rst_stall", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
      stall = 1'b0; Req = 1'b1;
      cyc();
      chk_all("rst_req", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
      reset = 1'b0; Req = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
